aes_key_schedule_seq: RTL and testbench

- Sequential AES-128 key expansion engine; sits directly upstream of the decryption round datapath and feeds its 128-bit round-key input.
- Computes one round key per clock from a loaded cipher key and stores all 11 round keys (rk0..rk10) in an internal buffer.
- The decryption sequencer reads keys by index through a registered read port (rk10 first, rk0 last).

---
 rtl/aes_key_schedule_seq.sv | 174 +++++++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key expansion: one round key per clock into an 11-entry
// buffer, read back through a one-cycle registered port (rk10 first for decryption).
module aes_key_schedule_seq #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid
);

    localparam int         NK       = NR + 1;
    localparam logic [3:0] LAST_IDX = 4'(NR);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] msb;
        msb = 11'd2047 - {x, 3'b000};
        return SBOX[msb -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [127:0]   work_q, work_d;
    logic           busy_q, busy_d;
    logic           keys_valid_q, keys_valid_d;
    logic [127:0]   rd_key_q, rd_key_d;
    logic           rd_valid_q, rd_valid_d;
    logic [127:0]   rk_q [NK];

    logic [127:0]   step_s;
    logic           wr_en_s;
    logic [3:0]     wr_idx_s;
    logic [127:0]   wr_data_s;
    logic           rd_ok_s;

    assign step_s = key_step(work_q, rcon_q);

    // Next-state logic for the expansion FSM, buffer write request and read port.
    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        rcon_d       = rcon_q;
        work_d       = work_q;
        busy_d       = busy_q;
        keys_valid_d = keys_valid_q;
        wr_en_s      = 1'b0;
        wr_idx_s     = round_q;
        wr_data_s    = step_s;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_EXPAND;
                    work_d       = key_in;
                    round_d      = 4'd1;
                    rcon_d       = 8'h01;
                    busy_d       = 1'b1;
                    keys_valid_d = 1'b0;
                    wr_en_s      = 1'b1;
                    wr_idx_s     = 4'd0;
                    wr_data_s    = key_in;
                end else begin
                    state_d = state_q;
                end
            end
            S_EXPAND: begin
                wr_en_s = 1'b1;
                work_d  = step_s;
                if (round_q == LAST_IDX) begin
                    state_d      = S_DONE;
                    busy_d       = 1'b0;
                    keys_valid_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                end
            end
            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                keys_valid_d = 1'b0;
            end
        endcase

        rd_ok_s = (rd_idx <= LAST_IDX);
        if (rd_ok_s) begin
            rd_key_d = rk_q[rd_idx];
        end else begin
            rd_key_d = 128'h0;
        end
        rd_valid_d = keys_valid_q && rd_ok_s;
    end

    // State, key buffer and registered outputs; the read samples pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            round_q      <= 4'd0;
            rcon_q       <= 8'h01;
            work_q       <= 128'h0;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q     <= 128'h0;
            rd_valid_q   <= 1'b0;
            for (int i = 0; i < NK; i++) begin
                rk_q[i] <= 128'h0;
            end
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            rcon_q       <= rcon_d;
            work_q       <= work_d;
            busy_q       <= busy_d;
            keys_valid_q <= keys_valid_d;
            rd_key_q     <= rd_key_d;
            rd_valid_q   <= rd_valid_d;
            if (wr_en_s) begin
                rk_q[wr_idx_s] <= wr_data_s;
            end
        end
    end

    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_valid;

    int n_vec;
    int n_err;

    aes_key_schedule_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         vld;
    } rd_vec_t;

    logic [127:0] fips_rk [11];
    rd_vec_t      sweep   [12];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic read_chk(input string name, input logic [3:0] idx,
                            input logic [127:0] exp_key, input logic exp_vld);
        rd_idx = idx;
        @(negedge clk);
        chk({name, "_key"}, rd_key, exp_key);
        chk({name, "_vld"}, {127'h0, rd_valid}, {127'h0, exp_vld});
    endtask

    // Pulse start with k, optionally pulse again with k2 three cycles in,
    // then measure busy length, keys_valid rise and rd_valid during expansion.
    task automatic do_expand(input logic [127:0] k, input bit extra, input logic [127:0] k2);
        int busy_cnt;
        int kv_at;
        int rdv_cnt;
        busy_cnt = 0;
        kv_at    = -1;
        rdv_cnt  = 0;
        rd_idx   = 4'd10;
        start    = 1'b1;
        key_in   = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~k;
        chk("busy_after_start", {127'h0, busy}, 128'h1);
        chk("kv_after_start", {127'h0, keys_valid}, 128'h0);
        for (int c = 0; c < 30; c++) begin
            if (busy) busy_cnt++;
            if (keys_valid && kv_at < 0) kv_at = c;
            if (c >= 1 && c <= 9 && rd_valid) rdv_cnt++;
            if (extra && c == 3) begin
                start  = 1'b1;
                key_in = k2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk_int("busy_cycles", busy_cnt, 10);
        chk_int("kv_rise_cycle", kv_at, 10);
        chk_int("rd_valid_during_expand", rdv_cnt, 0);
    endtask

    initial begin
        int act_cnt;
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = 128'h0;
        rd_idx = 4'd0;

        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) begin
            sweep[i].idx = 4'(10 - i);
            sweep[i].key = fips_rk[10 - i];
            sweep[i].vld = 1'b1;
        end
        sweep[11].idx = 4'd11;
        sweep[11].key = 128'h0;
        sweep[11].vld = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_kv", {127'h0, keys_valid}, 128'h0);
        chk("rst_rd_key", rd_key, 128'h0);
        chk("rst_rd_vld", {127'h0, rd_valid}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_chk("pre_key_read", 4'd0, 128'h0, 1'b0);

        // FIPS-197 expansion and reverse read sweep
        do_expand(FIPS_KEY, 1'b0, 128'h0);
        for (int i = 0; i < 12; i++) begin
            rd_idx = sweep[i].idx;
            @(negedge clk);
            chk($sformatf("sweep_key_%0d", sweep[i].idx), rd_key, sweep[i].key);
            chk($sformatf("sweep_vld_%0d", sweep[i].idx), {127'h0, rd_valid}, {127'h0, sweep[i].vld});
        end

        // Restart from DONE with the all-zero key
        do_expand(ZERO_KEY, 1'b0, 128'h0);
        read_chk("zero_rk0", 4'd0, ZERO_KEY, 1'b1);
        read_chk("zero_rk1", 4'd1, ZERO_RK1, 1'b1);
        read_chk("zero_rk10", 4'd10, ZERO_RK10, 1'b1);

        // Extra start during expansion must be ignored
        do_expand(FIPS_KEY, 1'b1, ZERO_KEY);
        read_chk("extra_rk0", 4'd0, fips_rk[0], 1'b1);
        read_chk("extra_rk5", 4'd5, fips_rk[5], 1'b1);
        read_chk("extra_rk10", 4'd10, fips_rk[10], 1'b1);
        read_chk("extra_rk1", 4'd1, fips_rk[1], 1'b1);

        // Reset during round 5
        start  = 1'b1;
        key_in = ZERO_KEY;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {127'h0, busy}, 128'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {127'h0, busy}, 128'h0);
        chk("midrst_kv", {127'h0, keys_valid}, 128'h0);
        chk("midrst_rd_key", rd_key, 128'h0);
        chk("midrst_rd_vld", {127'h0, rd_valid}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            read_chk($sformatf("cleared_%0d", i), 4'(i), 128'h0, 1'b0);
        end
        act_cnt = 0;
        rd_idx  = 4'd1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy || keys_valid || rd_valid) act_cnt++;
        end
        chk_int("idle_after_reset", act_cnt, 0);

        // Fresh start after reset works
        do_expand(FIPS_KEY, 1'b0, 128'h0);
        read_chk("post_rst_rk1", 4'd1, fips_rk[1], 1'b1);
        read_chk("post_rst_rk10", 4'd10, fips_rk[10], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
